// File: rtl/farm_road_sensor_conditioner_if.sv
// Signal bundle between the farm-road loop conditioner and its environment.
// The master drives the detector, grant and clear lines; the slave returns the conditioned request.
interface farm_road_sensor_conditioner_if;
  logic       loop_raw;
  logic       frg;
  logic       cnt_clr;
  logic       c;
  logic       presence;
  logic [7:0] vehicle_count;
  logic       busy;

  modport master (
    output loop_raw, frg, cnt_clr,
    input  c, presence, vehicle_count, busy
  );

  modport slave (
    input  loop_raw, frg, cnt_clr,
    output c, presence, vehicle_count, busy
  );
endinterface

// File: rtl/farm_road_sensor_conditioner.sv
// Turns the raw farm-road loop detector into the latched vehicle request 'c'.
// The request is held until farm green is granted, then re-armed only after a gap.
module farm_road_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_GAP_CYCLES  = 8,
  parameter int unsigned CNT_W           = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  farm_road_sensor_conditioner_if.slave bus
);

  localparam int unsigned VCNT_W   = 8;
  localparam logic [VCNT_W-1:0] VCNT_MAX = VCNT_W'(255);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(MIN_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVE   = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  logic              sync1_q;
  logic              sync2_q;
  logic [CNT_W-1:0]  deb_cnt_q;
  logic [CNT_W-1:0]  deb_cnt_d;
  logic              presence_q;
  logic              presence_d;
  logic              arrival_q;
  logic [VCNT_W-1:0] count_q;
  logic [VCNT_W-1:0] count_d;
  state_e            state_q;
  logic [CNT_W-1:0]  gap_q;
  logic              pending_q;
  logic              c_q;
  logic              busy_q;

  // Two-flop synchroniser for the asynchronous loop input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.loop_raw;
      sync2_q <= sync1_q;
    end
  end

  // Presence flips only after the synced loop has disagreed for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    deb_cnt_d  = '0;
    presence_d = presence_q;
    if (sync2_q != presence_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        presence_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.cnt_clr) begin
      count_d = arrival_q ? VCNT_W'(1) : '0;
    end else if (arrival_q && (count_q != VCNT_MAX)) begin
      count_d = count_q + VCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q  <= '0;
      presence_q <= 1'b0;
      arrival_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      presence_q <= presence_d;
      arrival_q  <= presence_d & ~presence_q;
      count_q    <= count_d;
    end
  end

  // Request FSM; c and busy are registered alongside each state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      pending_q <= 1'b0;
      c_q       <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (arrival_q && ((state_q == SERVE) || (state_q == HOLDOFF))) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (presence_q) begin
            state_q <= REQ;
            c_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (bus.frg) begin
            state_q <= SERVE;
            c_q     <= 1'b0;
          end
        end
        SERVE: begin
          if (!bus.frg) begin
            state_q <= HOLDOFF;
            gap_q   <= '0;
          end
        end
        HOLDOFF: begin
          if (gap_q == GAP_LAST) begin
            pending_q <= 1'b0;
            if (pending_q || presence_q) begin
              state_q <= REQ;
              c_q     <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_q <= gap_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          c_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.c             = c_q;
  assign bus.presence      = presence_q;
  assign bus.vehicle_count = count_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_farm_road_sensor_conditioner.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor compares after each edge.
module tb_farm_road_sensor_conditioner;
  localparam int unsigned D = 4;
  localparam int unsigned G = 8;
  localparam int P_IDLE = 0, P_REQ = 1, P_SERVE = 2, P_HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  farm_road_sensor_conditioner_if bus();

  farm_road_sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .MIN_GAP_CYCLES (G),
    .CNT_W          (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       c;
    logic       presence;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, kept in spec terms: sync pipeline, mismatch history, service phase.
  bit m_sq[$];
  bit m_diff[$];
  bit m_pres;
  bit m_arr;
  int m_count;
  int m_phase;
  int m_gap_left;
  bit m_pending;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sq.delete();
    m_sq.push_back(1'b0);
    m_sq.push_back(1'b0);
    m_diff.delete();
    m_pres     = 1'b0;
    m_arr      = 1'b0;
    m_count    = 0;
    m_phase    = P_IDLE;
    m_gap_left = 0;
    m_pending  = 1'b0;
  endfunction

  function automatic void model_edge(input bit loop, input bit frg, input bit clr);
    bit   ls;
    bit   all_diff;
    bit   new_pres;
    exp_t e;
    ls = m_sq.pop_front();
    m_sq.push_back(loop);
    m_diff.push_back(ls != m_pres);
    if (m_diff.size() > D) void'(m_diff.pop_front());
    all_diff = (m_diff.size() == D);
    foreach (m_diff[i]) if (!m_diff[i]) all_diff = 1'b0;
    new_pres = all_diff ? ~m_pres : m_pres;
    if (all_diff) m_diff.delete();

    if (clr) m_count = m_arr ? 1 : 0;
    else if (m_arr && m_count < 255) m_count++;

    if (m_arr && (m_phase == P_SERVE || m_phase == P_HOLD)) m_pending = 1'b1;
    case (m_phase)
      P_IDLE:  if (m_pres) m_phase = P_REQ;
      P_REQ:   if (frg) m_phase = P_SERVE;
      P_SERVE: if (!frg) begin m_phase = P_HOLD; m_gap_left = G; end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) begin
          m_phase   = (m_pending || m_pres) ? P_REQ : P_IDLE;
          m_pending = 1'b0;
        end
      end
    endcase

    m_arr  = new_pres & ~m_pres;
    m_pres = new_pres;

    e.c        = (m_phase == P_REQ);
    e.busy     = (m_phase != P_IDLE);
    e.presence = m_pres;
    e.cnt      = 8'(m_count);
    sb.push_back(e);
  endfunction

  task automatic step(input bit loop, input bit frg, input bit clr);
    @(negedge clk);
    rst          = 1'b0;
    bus.loop_raw = loop;
    bus.frg      = frg;
    bus.cnt_clr  = clr;
    model_edge(loop, frg, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.loop_raw = 1'b0;
    bus.frg      = 1'b0;
    bus.cnt_clr  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n, input bit loop, input bit frg);
    for (int i = 0; i < n; i++) step(loop, frg, 1'b0);
  endtask

  // Monitor: one expectation per clock edge that stimulus produced.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_c", 8'(bus.c), 8'(e.c));
        chk("sb_presence", 8'(bus.presence), 8'(e.presence));
        chk("sb_busy", 8'(bus.busy), 8'(e.busy));
        chk("sb_count", bus.vehicle_count, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int run;
    bit lv;
    bit fv;
    bus.loop_raw = 1'b0;
    bus.frg      = 1'b0;
    bus.cnt_clr  = 1'b0;
    model_reset();
    #1;
    chk("reset_c", 8'(bus.c), 8'd0);
    chk("reset_presence", 8'(bus.presence), 8'd0);
    chk("reset_busy", 8'(bus.busy), 8'd0);
    chk("reset_count", bus.vehicle_count, 8'd0);

    // Arrival latency: presence after edge 6, request after edge 7.
    do_reset();
    steps(5, 1'b1, 1'b0);
    sample();
    chk("lat_presence_e5", 8'(bus.presence), 8'd0);
    step(1'b1, 1'b0, 1'b0);
    sample();
    chk("lat_presence_e6", 8'(bus.presence), 8'd1);
    chk("lat_c_e6", 8'(bus.c), 8'd0);
    step(1'b1, 1'b0, 1'b0);
    sample();
    chk("lat_c_e7", 8'(bus.c), 8'd1);
    chk("lat_count_e7", bus.vehicle_count, 8'd1);

    // Request held without presence, then grant, gap, and return to idle.
    steps(20, 1'b0, 1'b0);
    sample();
    chk("hold_c", 8'(bus.c), 8'd1);
    step(1'b0, 1'b1, 1'b0);
    sample();
    chk("grant_c", 8'(bus.c), 8'd0);
    chk("grant_busy", 8'(bus.busy), 8'd1);
    steps(8, 1'b0, 1'b0);
    sample();
    chk("holdoff_busy_last", 8'(bus.busy), 8'd1);
    step(1'b0, 1'b0, 1'b0);
    sample();
    chk("holdoff_exit_busy", 8'(bus.busy), 8'd0);
    chk("holdoff_exit_c", 8'(bus.c), 8'd0);

    // Short glitch never reaches presence.
    do_reset();
    steps(3, 1'b1, 1'b0);
    steps(12, 1'b0, 1'b0);
    sample();
    chk("glitch_presence", 8'(bus.presence), 8'd0);
    chk("glitch_c", 8'(bus.c), 8'd0);
    chk("glitch_count", bus.vehicle_count, 8'd0);

    // Arrival during SERVE re-requests after the gap.
    do_reset();
    steps(8, 1'b1, 1'b0);
    steps(10, 1'b0, 1'b0);
    steps(2, 1'b0, 1'b1);
    steps(10, 1'b1, 1'b1);
    steps(10, 1'b0, 1'b1);
    steps(9, 1'b0, 1'b0);
    sample();
    chk("pending_rereq_c", 8'(bus.c), 8'd1);
    chk("pending_presence", 8'(bus.presence), 8'd0);

    // Saturating count, then clear coincident with an arrival.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      fv = 1'($urandom_range(0, 1));
      steps(6, 1'b1, fv);
      steps(6, 1'b0, fv);
    end
    sample();
    chk("count_saturated", bus.vehicle_count, 8'd255);
    for (int i = 0; i < 40 && !m_arr; i++) step(1'b1, 1'b0, 1'b0);
    if (!m_arr) begin
      checks++;
      errors++;
      $display("FAIL clr_arrival_wait: got 0 expected 1 (no arrival within bound)");
    end
    step(1'b1, 1'b0, 1'b1);
    sample();
    chk("clr_with_arrival", bus.vehicle_count, 8'd1);

    // Asynchronous reset in the middle of a request.
    do_reset();
    for (int i = 0; i < 40 && m_phase != P_REQ; i++) step(1'b1, 1'b0, 1'b0);
    if (m_phase != P_REQ) begin
      checks++;
      errors++;
      $display("FAIL req_wait: got %0d expected %0d", m_phase, P_REQ);
    end
    @(posedge clk);
    #2;
    chk("pre_async_c", 8'(bus.c), 8'd1);
    rst = 1'b1;
    #1;
    chk("async_c", 8'(bus.c), 8'd0);
    chk("async_presence", 8'(bus.presence), 8'd0);
    chk("async_count", bus.vehicle_count, 8'd0);
    chk("async_busy", 8'(bus.busy), 8'd0);
    model_reset();
    @(negedge clk);
    bus.loop_raw = 1'b0;
    @(negedge clk);
    steps(4, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    lv = 1'b0;
    fv = 1'b0;
    for (int i = 0; i < 150; i++) begin
      lv  = ~lv;
      run = $urandom_range(1, 10);
      for (int k = 0; k < run; k++) begin
        if ($urandom_range(0, 7) == 0) fv = ~fv;
        step(lv, fv, ($urandom_range(0, 49) == 0));
      end
    end
    steps(3, 1'b0, 1'b0);

    sample();
    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
